// File: rtl/dcache_write_arbiter.sv
// dcache_write_arbiter: round-robin AXI write arbiter for two requesters with in-order B routing
// Ports: m0_* (replace-queue burst writer) and m1_* (uncached store path) carry AW/W in and B out;
// s_* is the single AXI write master toward the bus; busy flags activity, proto_err is a sticky
// flag for a bus response that arrives with no outstanding write.
module dcache_write_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W = 4,
  parameter int OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_aw_valid,
  input  logic [ADDR_W-1:0]   m0_aw_addr,
  input  logic [7:0]          m0_aw_len,
  input  logic [2:0]          m0_aw_size,
  input  logic [ID_W-1:0]     m0_aw_id,
  output logic                m0_aw_ready,
  input  logic                m0_w_valid,
  input  logic [DATA_W-1:0]   m0_w_data,
  input  logic [DATA_W/8-1:0] m0_w_strb,
  input  logic                m0_w_last,
  output logic                m0_w_ready,
  output logic                m0_b_valid,
  output logic [1:0]          m0_b_resp,
  input  logic                m1_aw_valid,
  input  logic [ADDR_W-1:0]   m1_aw_addr,
  input  logic [7:0]          m1_aw_len,
  input  logic [2:0]          m1_aw_size,
  input  logic [ID_W-1:0]     m1_aw_id,
  output logic                m1_aw_ready,
  input  logic                m1_w_valid,
  input  logic [DATA_W-1:0]   m1_w_data,
  input  logic [DATA_W/8-1:0] m1_w_strb,
  input  logic                m1_w_last,
  output logic                m1_w_ready,
  output logic                m1_b_valid,
  output logic [1:0]          m1_b_resp,
  output logic                s_aw_valid,
  output logic [ADDR_W-1:0]   s_aw_addr,
  output logic [7:0]          s_aw_len,
  output logic [2:0]          s_aw_size,
  output logic [ID_W-1:0]     s_aw_id,
  input  logic                s_aw_ready,
  output logic                s_w_valid,
  output logic [DATA_W-1:0]   s_w_data,
  output logic [DATA_W/8-1:0] s_w_strb,
  output logic                s_w_last,
  input  logic                s_w_ready,
  input  logic                s_b_valid,
  input  logic [1:0]          s_b_resp,
  output logic                s_b_ready,
  output logic                busy,
  output logic                proto_err
);
  localparam int CW = $clog2(OUTSTANDING);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
  logic [1:0] state;
  logic gnt, rr, pick, in_addr, in_data, aw_hs, w_end, b_hs, empty, full;
  logic [OUTSTANDING-1:0] owner;
  logic [CW-1:0] wp, rp;
  logic [CW:0] cnt;
  assign empty = cnt == '0;
  assign full = cnt == (CW+1)'(OUTSTANDING);
  // both valid: pointer decides; otherwise whichever is asking
  assign pick = (m0_aw_valid && m1_aw_valid) ? rr : m1_aw_valid;
  // every handshake output is forced low while reset is asserted
  assign in_addr = !rst && state == ADDR;
  assign in_data = !rst && state == DATA;
  assign s_aw_valid = in_addr && (gnt ? m1_aw_valid : m0_aw_valid);
  assign s_aw_addr = gnt ? m1_aw_addr : m0_aw_addr;
  assign s_aw_len = gnt ? m1_aw_len : m0_aw_len;
  assign s_aw_size = gnt ? m1_aw_size : m0_aw_size;
  assign s_aw_id = gnt ? m1_aw_id : m0_aw_id;
  assign m0_aw_ready = in_addr && !gnt && s_aw_ready;
  assign m1_aw_ready = in_addr && gnt && s_aw_ready;
  assign s_w_valid = in_data && (gnt ? m1_w_valid : m0_w_valid);
  assign s_w_data = gnt ? m1_w_data : m0_w_data;
  assign s_w_strb = gnt ? m1_w_strb : m0_w_strb;
  assign s_w_last = gnt ? m1_w_last : m0_w_last;
  assign m0_w_ready = in_data && !gnt && s_w_ready;
  assign m1_w_ready = in_data && gnt && s_w_ready;
  assign s_b_ready = !rst && !empty;
  assign aw_hs = s_aw_valid && s_aw_ready;
  assign w_end = s_w_valid && s_w_ready && s_w_last;
  assign b_hs = s_b_valid && s_b_ready;
  // responses route by the oldest outstanding owner, never by s_b_id
  assign m0_b_valid = b_hs && !owner[rp];
  assign m1_b_valid = b_hs && owner[rp];
  assign m0_b_resp = s_b_resp;
  assign m1_b_resp = s_b_resp;
  assign busy = state != IDLE || !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      rr <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      if (state == IDLE && (m0_aw_valid || m1_aw_valid) && !full) begin
        state <= ADDR;
        gnt <= pick;
        rr <= !pick;
      end
      if (aw_hs) begin
        state <= DATA;
        owner[wp] <= gnt;
        wp <= wp + 1'b1;
      end
      if (w_end) state <= IDLE;
      if (b_hs) rp <= rp + 1'b1;
      cnt <= cnt + (CW+1)'(aw_hs) - (CW+1)'(b_hs);
      if (s_b_valid && empty) proto_err <= 1'b1;
    end
  end
endmodule
